// File: rtl/tdm_demux4_frame.sv
// 1-to-4 word demultiplexer with frame capture: routes a word stream into four
// registered channels and presents a complete frame with a valid/ack handshake.
module tdm_demux4_frame #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             use_ext,
  input  logic [1:0]       sel_ext,
  input  logic             clear,
  input  logic             frame_ack,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       wr_strobe,
  output logic [1:0]       chan,
  output logic             frame_valid
);

  // Handshakes: a word transfers on a rising edge where in_valid & in_ready;
  // a frame is released on a rising edge where frame_valid & frame_ack.
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t     state;
  logic [3:0] mask;
  logic [1:0] target;
  logic [3:0] target_oh;
  logic       accept;

  always_comb begin
    target    = use_ext ? sel_ext : chan;
    target_oh = 4'b0001 << target;
    in_ready  = (state == FILL);
    accept    = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FILL;
      mask        <= 4'b0000;
      chan        <= 2'd0;
      frame_valid <= 1'b0;
      wr_strobe   <= 4'b0000;
      y0          <= '0;
      y1          <= '0;
      y2          <= '0;
      y3          <= '0;
    end else begin
      wr_strobe <= 4'b0000;
      if (clear) begin
        // Flush outranks both a pending accept and a frame acknowledge.
        state       <= FILL;
        mask        <= 4'b0000;
        chan        <= 2'd0;
        frame_valid <= 1'b0;
      end else begin
        case (state)
          FILL: begin
            if (accept) begin
              case (target)
                2'd0:    y0 <= din;
                2'd1:    y1 <= din;
                2'd2:    y2 <= din;
                default: y3 <= din;
              endcase
              wr_strobe <= target_oh;
              mask      <= mask | target_oh;
              if (!use_ext) chan <= chan + 2'd1;
              // Completion depends only on the mask, so mixed modes still finish.
              if ((mask | target_oh) == 4'b1111) begin
                state       <= HOLD;
                frame_valid <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (frame_ack) begin
              state       <= FILL;
              mask        <= 4'b0000;
              chan        <= 2'd0;
              frame_valid <= 1'b0;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4_frame.sv
// Directed, table-driven bench for tdm_demux4_frame with a hand-written
// asynchronous-reset sequence.
module tb_tdm_demux4_frame;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] din;
  logic         in_valid;
  logic         in_ready;
  logic         use_ext;
  logic [1:0]   sel_ext;
  logic         clear;
  logic         frame_ack;
  logic [W-1:0] y0, y1, y2, y3;
  logic [3:0]   wr_strobe;
  logic [1:0]   chan;
  logic         frame_valid;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic         iv;
    logic [W-1:0] din;
    logic         ue;
    logic [1:0]   sel;
    logic         clr;
    logic         ack;
    logic [W-1:0] e0, e1, e2, e3;
    logic [3:0]   ews;
    logic [1:0]   ech;
    logic         efv;
    logic         erdy;
  } vec_t;

  vec_t vecs[$];

  tdm_demux4_frame #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .in_valid(in_valid),
    .in_ready(in_ready), .use_ext(use_ext), .sel_ext(sel_ext), .clear(clear),
    .frame_ack(frame_ack), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .wr_strobe(wr_strobe), .chan(chan), .frame_valid(frame_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic vec_t mk(logic iv, logic [W-1:0] d, logic ue, logic [1:0] sel,
                              logic clr, logic ack,
                              logic [W-1:0] e0, logic [W-1:0] e1,
                              logic [W-1:0] e2, logic [W-1:0] e3,
                              logic [3:0] ews, logic [1:0] ech, logic efv, logic erdy);
    vec_t v;
    v.iv = iv; v.din = d; v.ue = ue; v.sel = sel; v.clr = clr; v.ack = ack;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    v.ews = ews; v.ech = ech; v.efv = efv; v.erdy = erdy;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_outputs(string tag, logic [W-1:0] e0, logic [W-1:0] e1,
                               logic [W-1:0] e2, logic [W-1:0] e3, logic [3:0] ews,
                               logic [1:0] ech, logic efv, logic erdy);
    check({tag, " y"}, 64'({y0, y1, y2, y3}), 64'({e0, e1, e2, e3}));
    check({tag, " wr_strobe"}, 64'(wr_strobe), 64'(ews));
    check({tag, " chan"}, 64'(chan), 64'(ech));
    check({tag, " frame_valid"}, 64'(frame_valid), 64'(efv));
    check({tag, " in_ready"}, 64'(in_ready), 64'(erdy));
  endtask

  // driver: inputs change at negedge, outputs sampled 1 time unit after posedge
  task automatic run_vec(vec_t v, string tag);
    in_valid = v.iv; din = v.din; use_ext = v.ue; sel_ext = v.sel;
    clear = v.clr; frame_ack = v.ack;
    @(posedge clk);
    #1;
    check_outputs(tag, v.e0, v.e1, v.e2, v.e3, v.ews, v.ech, v.efv, v.erdy);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; din = '0; use_ext = 1'b0; sel_ext = 2'd0;
    clear = 1'b0; frame_ack = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset", 12'h000, 12'h000, 12'h000, 12'h000, 4'b0000, 2'd0, 1'b0, 1'b1);
    reset_n = 1'b1;

    // round-robin fill
    vecs.push_back(mk(1, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 12'h000, 4'b0001, 1, 0, 1));
    vecs.push_back(mk(1, 12'h555, 0, 0, 0, 0, 12'h000, 12'h555, 12'h000, 12'h000, 4'b0010, 2, 0, 1));
    vecs.push_back(mk(1, 12'hAAA, 0, 0, 0, 0, 12'h000, 12'h555, 12'hAAA, 12'h000, 4'b0100, 3, 0, 1));
    vecs.push_back(mk(1, 12'hFFF, 0, 0, 0, 0, 12'h000, 12'h555, 12'hAAA, 12'hFFF, 4'b1000, 0, 1, 0));
    // HOLD ignores in_valid, then ack
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 12'h123, 0, 0, 0, 0, 12'h000, 12'h555, 12'hAAA, 12'hFFF, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 12'h000, 0, 0, 0, 1, 12'h000, 12'h555, 12'hAAA, 12'hFFF, 4'b0000, 0, 0, 1));
    // external select with overwrite of y3
    vecs.push_back(mk(1, 12'hFFF, 1, 3, 0, 0, 12'h000, 12'h555, 12'hAAA, 12'hFFF, 4'b1000, 0, 0, 1));
    vecs.push_back(mk(1, 12'h0F0, 1, 3, 0, 0, 12'h000, 12'h555, 12'hAAA, 12'h0F0, 4'b1000, 0, 0, 1));
    vecs.push_back(mk(1, 12'h555, 1, 1, 0, 0, 12'h000, 12'h555, 12'hAAA, 12'h0F0, 4'b0010, 0, 0, 1));
    vecs.push_back(mk(1, 12'h000, 1, 0, 0, 0, 12'h000, 12'h555, 12'hAAA, 12'h0F0, 4'b0001, 0, 0, 1));
    vecs.push_back(mk(1, 12'hAAA, 1, 2, 0, 0, 12'h000, 12'h555, 12'hAAA, 12'h0F0, 4'b0100, 0, 1, 0));
    vecs.push_back(mk(0, 12'h000, 0, 0, 0, 1, 12'h000, 12'h555, 12'hAAA, 12'h0F0, 4'b0000, 0, 0, 1));
    // mid-frame clear drops 333
    vecs.push_back(mk(1, 12'h111, 0, 0, 0, 0, 12'h111, 12'h555, 12'hAAA, 12'h0F0, 4'b0001, 1, 0, 1));
    vecs.push_back(mk(1, 12'h222, 0, 0, 0, 0, 12'h111, 12'h222, 12'hAAA, 12'h0F0, 4'b0010, 2, 0, 1));
    vecs.push_back(mk(1, 12'h333, 0, 0, 1, 0, 12'h111, 12'h222, 12'hAAA, 12'h0F0, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(1, 12'h444, 0, 0, 0, 0, 12'h444, 12'h222, 12'hAAA, 12'h0F0, 4'b0001, 1, 0, 1));
    vecs.push_back(mk(1, 12'h555, 0, 0, 0, 0, 12'h444, 12'h555, 12'hAAA, 12'h0F0, 4'b0010, 2, 0, 1));
    vecs.push_back(mk(1, 12'h666, 0, 0, 0, 0, 12'h444, 12'h555, 12'h666, 12'h0F0, 4'b0100, 3, 0, 1));
    vecs.push_back(mk(1, 12'h777, 0, 0, 0, 0, 12'h444, 12'h555, 12'h666, 12'h777, 4'b1000, 0, 1, 0));
    // clear in HOLD keeps y
    vecs.push_back(mk(0, 12'h000, 0, 0, 1, 0, 12'h444, 12'h555, 12'h666, 12'h777, 4'b0000, 0, 0, 1));
    // frame_ack in FILL is ignored
    vecs.push_back(mk(1, 12'h888, 0, 0, 0, 0, 12'h888, 12'h555, 12'h666, 12'h777, 4'b0001, 1, 0, 1));
    vecs.push_back(mk(0, 12'h000, 0, 0, 0, 1, 12'h888, 12'h555, 12'h666, 12'h777, 4'b0000, 1, 0, 1));
    vecs.push_back(mk(1, 12'h999, 0, 0, 0, 1, 12'h888, 12'h999, 12'h666, 12'h777, 4'b0010, 2, 0, 1));
    vecs.push_back(mk(1, 12'hAAA, 0, 0, 0, 0, 12'h888, 12'h999, 12'hAAA, 12'h777, 4'b0100, 3, 0, 1));
    vecs.push_back(mk(1, 12'hBBB, 0, 0, 0, 0, 12'h888, 12'h999, 12'hAAA, 12'hBBB, 4'b1000, 0, 1, 0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));
    idle_inputs();

    // asynchronous reset while in HOLD, between clock edges
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs("async_reset", 12'h000, 12'h000, 12'h000, 12'h000, 4'b0000, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    run_vec(mk(1, 12'hC0C, 0, 0, 0, 0, 12'hC0C, 12'h000, 12'h000, 12'h000, 4'b0001, 1, 0, 1), "post_reset0");
    run_vec(mk(1, 12'hD0D, 0, 0, 0, 0, 12'hC0C, 12'hD0D, 12'h000, 12'h000, 4'b0010, 2, 0, 1), "post_reset1");
    run_vec(mk(0, 12'h000, 0, 0, 0, 0, 12'hC0C, 12'hD0D, 12'h000, 12'h000, 4'b0000, 2, 0, 1), "post_reset_idle");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
